interp_lin: RTL and testbench

INTERP_LIN -- requirements
Module: interp_lin

---
 rtl/interp_lin_if.sv | 34 +++
 rtl/interp_lin.sv | 128 ++++++++++++
 tb/tb_interp_lin.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/interp_lin_if.sv
// interp_lin_if: stream bundle for the linear interpolator.
//   s_axis_data_*  low-rate signed samples into the interpolator
//   m_axis_data_*  oversampled signed samples out to the modulator
// Modports:
//   slave  - view taken by the interpolator itself
//   master - view taken by the surrounding logic (source + sink)
interface interp_lin_if #(
    parameter int unsigned WIDTH = 16
);
    logic signed [WIDTH-1:0] s_axis_data_tdata;
    logic                    s_axis_data_tvalid;
    logic                    s_axis_data_tready;
    logic signed [WIDTH-1:0] m_axis_data_tdata;
    logic                    m_axis_data_tvalid;
    logic                    m_axis_data_tready;

    modport slave (
        input  s_axis_data_tdata,
        input  s_axis_data_tvalid,
        output s_axis_data_tready,
        output m_axis_data_tdata,
        output m_axis_data_tvalid,
        input  m_axis_data_tready
    );

    modport master (
        output s_axis_data_tdata,
        output s_axis_data_tvalid,
        input  s_axis_data_tready,
        input  m_axis_data_tdata,
        input  m_axis_data_tvalid,
        output m_axis_data_tready
    );
endinterface

// File: rtl/interp_lin.sv
// interp_lin: linear interpolator, 1 input sample -> 2**OSR_LOG2 output samples.
// Each output period ramps from the previous accepted sample towards the
// newest one; outputs are the accumulator floored by OSR.
// Ports:
//   aclk      clock, rising edge
//   arst_n    synchronous active-low reset
//   bus       interp_lin_if.slave (s_axis_data_* in, m_axis_data_* out)
//   underrun  sticky: no input was available at a period boundary
module interp_lin #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned OSR_LOG2 = 4
) (
    input  logic        aclk,
    input  logic        arst_n,
    interp_lin_if.slave bus,
    output logic        underrun
);
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned AW = WIDTH + OSR_LOG2 + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic signed [WIDTH-1:0] cur_q,   cur_d;
    logic signed [SW-1:0]    step_q,  step_d;
    logic signed [AW-1:0]    acc_q,   acc_d;
    logic [OSR_LOG2-1:0]     phase_q, phase_d;
    logic                    underrun_q, underrun_d;

    logic                    s_tready_c;
    logic                    m_tvalid_c;
    logic                    last_phase;
    logic signed [SW-1:0]    x_ext;
    logic signed [SW-1:0]    cur_ext;
    logic signed [SW-1:0]    diff;
    logic signed [AW-1:0]    acc_base;
    logic signed [AW-1:0]    step_ext;

    // phase all-ones marks the final output of the period
    assign last_phase = &phase_q;

    // Difference at WIDTH+1 bits so full-scale swings never wrap
    assign x_ext    = {bus.s_axis_data_tdata[WIDTH-1], bus.s_axis_data_tdata};
    assign cur_ext  = {cur_q[WIDTH-1], cur_q};
    assign diff     = x_ext - cur_ext;

    // Period start point (cur * OSR) and step widened to accumulator size
    assign acc_base = {cur_q[WIDTH-1], cur_q, {OSR_LOG2{1'b0}}};
    assign step_ext = {{OSR_LOG2{step_q[SW-1]}}, step_q};

    // Output = floor(acc / OSR); acc always lies between two samples so it fits
    assign bus.m_axis_data_tdata  = acc_q[WIDTH+OSR_LOG2-1:OSR_LOG2];
    assign bus.m_axis_data_tvalid = m_tvalid_c;
    assign bus.s_axis_data_tready = s_tready_c;
    assign underrun               = underrun_q;

    // Next-state and handshake logic
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        step_d     = step_q;
        acc_d      = acc_q;
        phase_d    = phase_q;
        underrun_d = underrun_q;
        s_tready_c = 1'b0;
        m_tvalid_c = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                s_tready_c = 1'b1;
                if (bus.s_axis_data_tvalid) begin
                    // First segment ramps up from zero
                    step_d  = x_ext;
                    acc_d   = '0;
                    phase_d = '0;
                    cur_d   = bus.s_axis_data_tdata;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                m_tvalid_c = 1'b1;
                s_tready_c = bus.m_axis_data_tready & last_phase;
                if (bus.m_axis_data_tready) begin
                    if (!last_phase) begin
                        acc_d   = acc_q + step_ext;
                        phase_d = phase_q + OSR_LOG2'(1);
                    end else begin
                        acc_d   = acc_base;
                        phase_d = '0;
                        if (bus.s_axis_data_tvalid) begin
                            step_d = diff;
                            cur_d  = bus.s_axis_data_tdata;
                        end else begin
                            // Starved: hold the last sample for a full period
                            step_d     = '0;
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State register
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q    <= ST_EMPTY;
            cur_q      <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_interp_lin.sv
// tb_interp_lin: directed + randomized checks of interp_lin (WIDTH=16, OSR=4)
// against a segment-interpolation reference model.
module tb_interp_lin;
    localparam int W   = 16;
    localparam int L   = 2;
    localparam int OSR = 4;

    logic aclk   = 1'b0;
    logic arst_n = 1'b0;
    logic underrun;

    interp_lin_if #(.WIDTH(W)) bus ();

    interp_lin #(.WIDTH(W), .OSR_LOG2(L)) dut (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .bus      (bus),
        .underrun (underrun)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    int inq[$];
    int outs[$];
    int exp_q[$];
    int xs[$];

    // Reference model: current segment prev -> cur, position k inside it
    bit m_started;
    int m_k;
    int m_prev;
    int m_cur;
    bit m_ur;

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic one_cycle(input bit rand_mr);
        logic sv;
        logic mr;
        int   sd;
        int   exp_data;
        bit   exp_tr;
        bit   in_hs;
        bit   out_hs;
        @(negedge aclk);
        sv = (inq.size() > 0);
        sd = sv ? inq[0] : (int'($urandom_range(0, 65535)) - 32768);
        mr = rand_mr ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.s_axis_data_tvalid = sv;
        bus.s_axis_data_tdata  = 16'(sd);
        bus.m_axis_data_tready = mr;
        #1;
        exp_tr = !m_started ? 1'b1 : (mr && (m_k == OSR - 1));
        chk("s_tready", bus.s_axis_data_tready, exp_tr);
        chk("m_tvalid", bus.m_axis_data_tvalid, m_started);
        chk("underrun", underrun, m_ur);
        if (m_started) begin
            exp_data = m_prev + floor_div(m_k * (m_cur - m_prev), OSR);
            chk("m_tdata", bus.m_axis_data_tdata, exp_data);
        end
        in_hs  = sv && exp_tr;
        out_hs = m_started && mr;
        if (out_hs) outs.push_back(int'(bus.m_axis_data_tdata));
        @(posedge aclk);
        if (!m_started) begin
            if (in_hs) begin
                m_started = 1'b1;
                m_prev    = 0;
                m_cur     = sd;
                m_k       = 0;
            end
        end else if (out_hs) begin
            if (m_k < OSR - 1) begin
                m_k++;
            end else begin
                m_k    = 0;
                m_prev = m_cur;
                if (in_hs) m_cur = sd;
                else       m_ur  = 1'b1;
            end
        end
        if (in_hs) void'(inq.pop_front());
    endtask

    task automatic run_cycles(input int n, input bit rand_mr);
        for (int i = 0; i < n; i++) one_cycle(rand_mr);
    endtask

    task automatic run_until(input int target, input bit rand_mr, input int budget);
        int cyc;
        cyc = 0;
        while (outs.size() < target && cyc < budget) begin
            one_cycle(rand_mr);
            cyc++;
        end
        chk("run_budget", (outs.size() >= target), 1);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arst_n = 1'b0;
        bus.s_axis_data_tvalid = 1'b0;
        bus.m_axis_data_tready = 1'b1;
        @(posedge aclk);
        m_started = 1'b0;
        m_k = 0; m_prev = 0; m_cur = 0; m_ur = 1'b0;
        inq.delete();
        outs.delete();
        @(negedge aclk);
        arst_n = 1'b1;
        #1;
        chk("rst_m_tvalid", bus.m_axis_data_tvalid, 0);
        chk("rst_s_tready", bus.s_axis_data_tready, 1);
        chk("rst_underrun", underrun, 0);
    endtask

    initial begin
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tdata  = '0;
        bus.m_axis_data_tready = 1'b1;

        // Basic ramp 400 -> 800
        do_reset();
        inq = '{400, 800};
        run_cycles(9, 1'b0);
        for (int i = 0; i < 8; i++) chk("ramp_400_800", outs[i], i * 100);

        // Floor rounding on a negative step
        do_reset();
        inq = '{0, -3};
        run_cycles(9, 1'b0);
        for (int i = 0; i < 4; i++) chk("floor_neg", outs[4 + i], -i);

        // Full-scale swing, no wrap
        do_reset();
        inq = '{32767, -32768};
        run_cycles(9, 1'b0);
        chk("fs_start", outs[4], 32767);
        for (int i = 5; i < 8; i++) chk("fs_monotone", (outs[i] < outs[i - 1]), 1);
        chk("fs_last", outs[7], -16385);

        // Random samples, free-running then with random back-pressure
        xs.delete();
        for (int i = 0; i < 8; i++) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
        exp_q.delete();
        for (int p = 0; p < 8; p++)
            for (int k = 0; k < OSR; k++)
                exp_q.push_back(((p == 0) ? 0 : xs[p - 1]) +
                    floor_div(k * (xs[p] - ((p == 0) ? 0 : xs[p - 1])), OSR));
        do_reset();
        inq = xs;
        run_until(32, 1'b0, 100);
        for (int i = 0; i < 32; i++) chk("rand_free", outs[i], exp_q[i]);
        do_reset();
        inq = xs;
        run_until(32, 1'b1, 600);
        for (int i = 0; i < 32; i++) chk("rand_stall", outs[i], exp_q[i]);

        // Input withheld at a boundary: hold and sticky underrun
        do_reset();
        inq = '{100, 200};
        run_cycles(13, 1'b0);
        for (int i = 8; i < 12; i++) chk("hold_cur", outs[i], 200);
        chk("underrun_set", underrun, 1);
        inq.push_back(300);
        run_cycles(5, 1'b0);
        chk("underrun_sticky", underrun, 1);
        chk("after_hold", outs[16], 200);

        // Reset in the middle of a period, then restart from zero
        do_reset();
        inq = '{400, 800};
        run_cycles(3, 1'b0);
        do_reset();
        inq = '{40};
        run_cycles(5, 1'b0);
        for (int i = 0; i < 4; i++) chk("restart", outs[i], i * 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
